// File: rtl/vm_controller.sv
// Vending-machine controller: coin credit, product release handshake and
// coin-by-coin change dispensing from per-denomination stock.
module vm_controller #(
  parameter int unsigned NUM_PRODUCTS = 10,
  parameter int unsigned PRICE_STEP   = 5,
  parameter int unsigned MAX_CREDIT   = 200,
  parameter int unsigned COIN_INIT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] money,
  input  logic       money_valid,
  input  logic [3:0] product_code,
  input  logic       buy,
  input  logic       product_ready,
  output logic [3:0] ready_product_code,
  output logic       product_valid,
  output logic       busy,
  output logic [3:0] change_denomination_code,
  output logic       change_valid,
  output logic       no_change
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] stock_q [6];
  logic [7:0] stock_d [6];
  logic [3:0] rcode_q, rcode_d;
  logic [3:0] ccode_q, ccode_d;
  logic       pv_q, pv_d;
  logic       busy_q, busy_d;
  logic       cv_q, cv_d;
  logic       nc_q, nc_d;

  function automatic logic [7:0] coin_value(input logic [2:0] code);
    case (code)
      3'd0:    coin_value = 8'd1;
      3'd1:    coin_value = 8'd2;
      3'd2:    coin_value = 8'd5;
      3'd3:    coin_value = 8'd10;
      3'd4:    coin_value = 8'd20;
      3'd5:    coin_value = 8'd50;
      default: coin_value = 8'd0;
    endcase
  endfunction

  logic        coin_ok;
  logic [8:0]  credit_sum;
  logic [11:0] price;
  logic        code_ok;
  logic        pay_ok;
  logic        found;
  logic [2:0]  sel;

  assign coin_ok    = money < 4'd6;
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_value(money[2:0])};
  assign price      = (12'(product_code) + 12'd1) * 12'(PRICE_STEP);
  assign code_ok    = {1'b0, product_code} < 5'(NUM_PRODUCTS);
  assign pay_ok     = {4'b0, credit_q} >= price;

  // Ascending scan: the last hit is the largest usable denomination.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (coin_value(3'(i)) <= remaining_q && stock_q[i] != 8'd0) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    remaining_d = remaining_q;
    stock_d     = stock_q;
    rcode_d     = rcode_q;
    pv_d        = pv_q;
    busy_d      = busy_q;
    cv_d        = 1'b0;
    ccode_d     = '0;
    nc_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (money_valid && coin_ok && credit_sum <= 9'(MAX_CREDIT)) begin
          credit_d = credit_sum[7:0];
          if (stock_q[money[2:0]] != 8'hFF)
            stock_d[money[2:0]] = stock_q[money[2:0]] + 8'd1;
        end
        if (buy && !money_valid && code_ok && pay_ok) begin
          rcode_d     = product_code;
          remaining_d = credit_q - price[7:0];
          credit_d    = '0;
          pv_d        = 1'b1;
          busy_d      = 1'b1;
          state_d     = VEND;
        end
      end
      VEND: begin
        if (product_ready) begin
          pv_d    = 1'b0;
          rcode_d = '0;
          state_d = CHANGE;
        end
      end
      CHANGE: begin
        if (remaining_q == 8'd0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (found) begin
          cv_d         = 1'b1;
          ccode_d      = {1'b0, sel};
          remaining_d  = remaining_q - coin_value(sel);
          stock_d[sel] = stock_q[sel] - 8'd1;
        end else begin
          // Residue is forfeited; the zero-remaining pass then returns to IDLE.
          nc_d        = 1'b1;
          remaining_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      remaining_q <= '0;
      for (int unsigned i = 0; i < 6; i++) stock_q[i] <= 8'(COIN_INIT);
      rcode_q     <= '0;
      pv_q        <= 1'b0;
      busy_q      <= 1'b0;
      cv_q        <= 1'b0;
      ccode_q     <= '0;
      nc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      remaining_q <= remaining_d;
      stock_q     <= stock_d;
      rcode_q     <= rcode_d;
      pv_q        <= pv_d;
      busy_q      <= busy_d;
      cv_q        <= cv_d;
      ccode_q     <= ccode_d;
      nc_q        <= nc_d;
    end
  end

  assign ready_product_code       = rcode_q;
  assign product_valid            = pv_q;
  assign busy                     = busy_q;
  assign change_denomination_code = ccode_q;
  assign change_valid             = cv_q;
  assign no_change                = nc_q;

endmodule

// File: tb/tb_vm_controller.sv
// Bench for vm_controller: per-cycle vector table with a scoreboard queue,
// plus a hand sequence on a zero-stock instance for the no_change path.
module tb_vm_controller;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, money_valid, buy, product_ready;
  logic [3:0] money, product_code;
  logic [3:0] ready_product_code, change_denomination_code;
  logic       product_valid, busy, change_valid, no_change;

  logic       b_rst, b_mv, b_buy, b_pr;
  logic [3:0] b_m, b_pc;
  logic [3:0] b_rc, b_cc;
  logic       b_pv, b_busy, b_cv, b_nc;

  vm_controller #(.NUM_PRODUCTS(10), .PRICE_STEP(5), .MAX_CREDIT(200), .COIN_INIT(4)) dut (
    .clk(clk), .rst(rst), .money(money), .money_valid(money_valid),
    .product_code(product_code), .buy(buy), .product_ready(product_ready),
    .ready_product_code(ready_product_code), .product_valid(product_valid), .busy(busy),
    .change_denomination_code(change_denomination_code), .change_valid(change_valid),
    .no_change(no_change));

  vm_controller #(.NUM_PRODUCTS(10), .PRICE_STEP(5), .MAX_CREDIT(200), .COIN_INIT(0)) dut0 (
    .clk(clk), .rst(b_rst), .money(b_m), .money_valid(b_mv),
    .product_code(b_pc), .buy(b_buy), .product_ready(b_pr),
    .ready_product_code(b_rc), .product_valid(b_pv), .busy(b_busy),
    .change_denomination_code(b_cc), .change_valid(b_cv), .no_change(b_nc));

  // exp = {product_valid, ready_product_code, busy, change_valid, change_code, no_change}
  typedef struct packed {
    logic        rst;
    logic        mv;
    logic [3:0]  m;
    logic        buy;
    logic [3:0]  pc;
    logic        pr;
    logic [11:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic void add(input logic r, input logic mv, input logic [3:0] m,
                              input logic b, input logic [3:0] pc, input logic pr,
                              input logic pv, input logic [3:0] rc, input logic bs,
                              input logic cv, input logic [3:0] cc, input logic nc);
    vec_t v;
    v.rst = r; v.mv = mv; v.m = m; v.buy = b; v.pc = pc; v.pr = pr;
    v.exp = {pv, rc, bs, cv, cc, nc};
    tbl.push_back(v);
  endfunction

  task automatic apply(input int idx, input vec_t v);
    logic [11:0] act, exp;
    @(negedge clk);
    rst = v.rst; money_valid = v.mv; money = v.m;
    buy = v.buy; product_code = v.pc; product_ready = v.pr;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    act = {product_valid, ready_product_code, busy, change_valid, change_denomination_code, no_change};
    exp = exp_q.pop_front();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d: got pv=%b rc=%0d busy=%b cv=%b cc=%0d nc=%b, want pv=%b rc=%0d busy=%b cv=%b cc=%0d nc=%b",
               idx, act[11], act[10:7], act[6], act[5], act[4:1], act[0],
               exp[11], exp[10:7], exp[6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  task automatic check(input string name, input logic ok, input int got, input int want);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int cv_cnt, nc_cnt;
    logic done;

    rst = 1'b1; money_valid = 1'b0; money = '0; buy = 1'b0; product_code = '0; product_ready = 1'b0;
    b_rst = 1'b1; b_mv = 1'b0; b_m = '0; b_buy = 1'b0; b_pc = '0; b_pr = 1'b0;

    //  rst mv m  buy pc pr   pv rc bs cv cc nc
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // overpay: 20 + 5, product 2 (15) -> one 10 coin
    add(0, 1, 4, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2, 0,   1, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 3, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // exact pay: 10, product 1
    add(0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0,   1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // refusals: short credit, bad code; then 30 buys product 4 -> 5 back
    add(0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 4, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 12, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 4, 0,   1, 4, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 2, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 9, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    // coin with simultaneous buy: coin kept (credit 5), buy dropped
    add(0, 1, 2, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // credit 50, product 0, stalled consumer, inputs during VEND ignored
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 1, 5, 1, 1, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 4, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 4, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 2, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // credit ceiling: 4x50 = 200 accepted, +1 refused; product 9 -> 3x50 back
    add(0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 9, 0,   1, 9, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 5, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 5, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 5, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // reset in the middle of a multi-coin change
    add(0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 4, 0);
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) apply(i, tbl[i]);
    check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);

    // zero-stock instance: 10 in, product 0 (5) -> change cannot be paid
    @(negedge clk); b_rst = 1'b0; b_mv = 1'b1; b_m = 4'd3;
    @(negedge clk); b_mv = 1'b0; b_buy = 1'b1; b_pc = 4'd0;
    @(negedge clk); b_buy = 1'b0;
    check("nochg_pv", b_pv === 1'b1 && b_rc === 4'd0 && b_busy === 1'b1, {b_pv, b_rc}, 16);
    b_pr = 1'b1;
    cv_cnt = 0; nc_cnt = 0; done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      b_pr = 1'b0;
      if (b_cv === 1'b1) cv_cnt++;
      if (b_nc === 1'b1) nc_cnt++;
      if (b_busy === 1'b0) done = 1'b1;
    end
    check("nochg_idle", done, int'(done), 1);
    check("nochg_pulses", nc_cnt == 1, nc_cnt, 1);
    check("nochg_no_coin", cv_cnt == 0, cv_cnt, 0);
    check("nochg_outs_clear", b_pv === 1'b0 && b_cv === 1'b0 && b_nc === 1'b0, {b_pv, b_cv, b_nc}, 0);
    // residue forfeited and credit cleared: an unfunded buy must not vend
    b_buy = 1'b1; b_pc = 4'd0;
    @(negedge clk); b_buy = 1'b0;
    check("nochg_credit0", b_pv === 1'b0 && b_busy === 1'b0, {b_pv, b_busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vm_controller.md
Name: vm_controller

Overview:
- Core vending-machine controller behind the driver/monitor signal set: accepts coins and purchase requests from the driver side, and hands a product to the consumer side.
- Returns change one coin per cycle from a per-denomination coin stock.
- Sole sequencer of credit, product release and change dispensing; busy tells the driver when new input is ignored.

Parameters:
- NUM_PRODUCTS, 10, valid product codes are 0..NUM_PRODUCTS-1 (at most 16).
- PRICE_STEP, 5, price(p) = (p+1)*PRICE_STEP units.
- MAX_CREDIT, 200, credit ceiling in units (must be ≤255).
- COIN_INIT, 4, initial stock per denomination after reset (≤255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- money  input  4  denomination code of inserted coin
- money_valid  input  1  coin present this cycle
- product_code  input  4  requested product
- buy  input  1  purchase request this cycle
- product_ready  input  1  consumer takes the presented product
- ready_product_code  output  4  code of product being released
- product_valid  output  1  product presented
- busy  output  1  vend/change in progress; inputs ignored
- change_denomination_code  output  4  denomination of change coin this cycle
- change_valid  output  1  change coin valid this cycle
- no_change  output  1  one-cycle pulse: remaining change cannot be paid

Behaviour:
- Denomination codes and values: 0=1, 1=2, 2=5, 3=10, 4=20, 5=50. Codes 6..15 are invalid.
- State: 8-bit credit, 8-bit remaining, six 8-bit stock counters.
- Reset (sync, rst=1 at edge): state IDLE; credit=0, remaining=0, every stock=COIN_INIT. All outputs are 0 (including both code outputs). Reset takes effect in any state, including mid-VEND or mid-CHANGE; in-flight change is discarded.
- All outputs are registered.

- State IDLE (busy=0):
  - money_valid with a valid code and credit+value ≤ MAX_CREDIT: credit += value; that denomination's stock += 1, saturating at 255.
  - Invalid code, or a coin that would exceed MAX_CREDIT: coin ignored, nothing changes.
  - buy with money_valid=0, product_code < NUM_PRODUCTS and credit ≥ price: latch the code; remaining = credit - price; credit = 0; go to VEND.
  - Any other buy (invalid code, insufficient credit, or buy in the same cycle as money_valid): ignored. The coin is still processed and credit is retained.
- State VEND (busy=1):
  - product_valid=1 and ready_product_code = latched code, held stable until a cycle with product_ready=1.
  - On that cycle: go to CHANGE; product_valid=0 and ready_product_code=0 from the next cycle.
  - product_ready outside VEND is ignored.
- State CHANGE (busy=1), evaluated every cycle:
  - remaining = 0: go to IDLE.
  - Otherwise select the largest denomination with value ≤ remaining and stock > 0.
    - If found: for exactly one cycle (the next cycle) change_valid=1 and change_denomination_code = that code; remaining -= value; that stock -= 1.
    - If none is usable: no_change=1 for one cycle, remaining = 0 (the residue is forfeited), go to IDLE.
- Outputs change_valid and no_change fall to 0 in any cycle with no new coin or pulse.
- busy is 1 in VEND and CHANGE and drops in the cycle after the last coin or the no_change pulse.
- money_valid and buy while busy=1 are ignored entirely.
- Credit never exceeds MAX_CREDIT; no arithmetic wraps.

Timing (handshake cycle T = cycle with product_valid and product_ready both 1):
- buy accepted at edge N: product_valid=1 from cycle N+1.
- First change coin is visible in cycle T+2.
- Subsequent coins follow back-to-back, one per cycle.

Test Plan:
- Overpay: insert 20 (code 4), then 5 (code 2); buy product 2 (price 15); product_ready in the first VEND cycle -> product_valid with code 2 for one cycle; one change coin, code 3 (value 10); no_change=0; busy then returns to 0.
- Exact pay: insert 10; buy product 1 (price 10) -> product released; change_valid never asserted; busy falls two cycles after the handshake.
- Refusals: insert 10; buy product 4 (price 25) -> ignored, busy=0. Buy product 12 -> ignored. Then insert 20 and buy product 4 -> change of 5, code 2. Insert code 9 -> credit unchanged.
- Multi-coin change and product stall: credit 50; buy product 0 (price 5); hold product_ready=0 for 3 cycles -> product_valid held with code 0. After ready: change is 20, 20, 5 on consecutive cycles (codes 4, 4, 2); stock of code 4 decremented by 2.
- Stock exhaustion (COIN_INIT=0): insert 10; buy product 0 -> product released; no_change pulses once, no change_valid; then IDLE with credit 0.
- Busy and reset: money_valid and buy during VEND -> ignored. Assert rst during the CHANGE state of a multi-coin change -> the next cycle has all outputs 0 and state IDLE; a following insert of 5 yields credit 5.
